// File: rtl/gif_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : gif_frame_loader
// Brief    : Streams the selected GIF frame from ROM into the hidden bank of a
//            ping-pong display buffer and swaps banks on scanner vsync.
// Revision : 1.0 - initial release
// ============================================================================
module gif_frame_loader #(
    parameter int TOTAL_FRAMES = 4,
    parameter int FRAME_W      = 2,
    parameter int PIXELS       = 64,
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FRAME_W-1:0]        frame_actual,
    input  logic                      frame_changed,
    input  logic                      disp_vsync,
    output logic [FRAME_W+ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      buf_we,
    output logic [ADDR_W:0]           buf_waddr,
    output logic [DATA_W-1:0]         buf_wdata,
    output logic                      disp_bank,
    output logic                      frame_ready,
    output logic                      busy
);

    localparam logic [ADDR_W-1:0]  c_last_pix   = ADDR_W'(PIXELS - 1);
    localparam logic [FRAME_W-1:0] c_last_frame = FRAME_W'(TOTAL_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } state_t;

    state_t                      r_state;
    logic [FRAME_W-1:0]          r_load_frame;
    logic [ADDR_W-1:0]           r_pix;
    logic                        r_pending;
    logic [FRAME_W-1:0]          r_pending_frame;
    logic                        r_rd_v;
    logic [ADDR_W-1:0]           r_rd_pix;
    logic [FRAME_W+ADDR_W-1:0]   r_rom_addr;
    logic                        r_buf_we;
    logic [ADDR_W:0]             r_buf_waddr;
    logic [DATA_W-1:0]           r_buf_wdata;
    logic                        r_disp_bank;
    logic                        r_frame_ready;
    logic                        r_busy;

    logic [FRAME_W-1:0]          w_req_frame;
    logic [ADDR_W-1:0]           w_pix_next;

    always_comb begin
        w_req_frame = frame_actual;
        if ({{(32-FRAME_W){1'b0}}, frame_actual} >= 32'(TOTAL_FRAMES))
            w_req_frame = c_last_frame;
    end

    assign w_pix_next = r_pix + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_load_frame    <= '0;
            r_pix           <= '0;
            r_pending       <= 1'b1;
            r_pending_frame <= '0;
            r_rd_v          <= 1'b0;
            r_rd_pix        <= '0;
            r_rom_addr      <= '0;
            r_buf_we        <= 1'b0;
            r_buf_waddr     <= '0;
            r_buf_wdata     <= '0;
            r_disp_bank     <= 1'b0;
            r_frame_ready   <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_frame_ready <= 1'b0;
            // ROM answers one cycle after the address, so writes trail issue by two.
            r_rd_v        <= (r_state == ST_LOAD);
            r_rd_pix      <= r_pix;
            r_buf_we      <= r_rd_v;
            if (r_rd_v) begin
                r_buf_waddr <= {~r_disp_bank, r_rd_pix};
                r_buf_wdata <= rom_data;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_pending) begin
                        r_state      <= ST_LOAD;
                        r_load_frame <= r_pending_frame;
                        r_pix        <= '0;
                        r_rom_addr   <= {r_pending_frame, {ADDR_W{1'b0}}};
                        r_busy       <= 1'b1;
                        r_pending    <= frame_changed;
                        if (frame_changed)
                            r_pending_frame <= w_req_frame;
                    end else if (frame_changed) begin
                        r_state      <= ST_LOAD;
                        r_load_frame <= w_req_frame;
                        r_pix        <= '0;
                        r_rom_addr   <= {w_req_frame, {ADDR_W{1'b0}}};
                        r_busy       <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (r_pix == c_last_pix) begin
                        r_state <= ST_DRAIN;
                        r_pix   <= '0;
                    end else begin
                        r_pix      <= w_pix_next;
                        r_rom_addr <= {r_load_frame, w_pix_next};
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_WAIT_SWAP;
                end
                ST_WAIT_SWAP: begin
                    if (disp_vsync) begin
                        r_state       <= ST_IDLE;
                        r_disp_bank   <= ~r_disp_bank;
                        r_frame_ready <= 1'b1;
                        r_busy        <= r_pending | frame_changed;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Requests arriving mid-load are queued; the newest one wins.
            if (frame_changed && (r_state != ST_IDLE)) begin
                r_pending       <= 1'b1;
                r_pending_frame <= w_req_frame;
            end
        end
    end

    assign rom_addr    = r_rom_addr;
    assign buf_we      = r_buf_we;
    assign buf_waddr   = r_buf_waddr;
    assign buf_wdata   = r_buf_wdata;
    assign disp_bank   = r_disp_bank;
    assign frame_ready = r_frame_ready;
    assign busy        = r_busy;

endmodule
`default_nettype wire
